// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// Module   : uart_pkg
// Brief    : Parity-mode constants, FSM state encodings and divisor helper
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int c_parity_none = 0;
  localparam int c_parity_even = 1;
  localparam int c_parity_odd  = 2;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // Integer-truncated clock cycles per period of the given rate.
  function automatic int uart_div(input int clk_freq, input int rate);
    return clk_freq / rate;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ----------------------------------------------------------------------------
// Module   : uart_baud_gen
// Brief    : TX bit-period tick and RX oversample tick, each phase-aligned to
//            the start of its own activity window
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic tx_run,
  input  logic rx_run,
  output logic tx_tick,
  output logic os_tick
);

  localparam int c_baud_div = uart_div(CLK_FREQ, BAUD_RATE);
  localparam int c_os_div   = uart_div(CLK_FREQ, BAUD_RATE * OVERSAMPLE);
  localparam int c_tx_w     = $clog2(c_baud_div + 1);
  localparam int c_os_w     = $clog2(c_os_div + 1);

  logic [c_tx_w-1:0] r_tx_cnt;
  logic [c_os_w-1:0] r_os_cnt;
  logic              w_tx_wrap;
  logic              w_os_wrap;

  assign w_tx_wrap = (r_tx_cnt == c_tx_w'(c_baud_div - 1));
  assign w_os_wrap = (r_os_cnt == c_os_w'(c_os_div - 1));
  assign tx_tick   = tx_run & w_tx_wrap;
  assign os_tick   = rx_run & w_os_wrap;

  // Counters idle at zero so the first period starts exactly when run rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_cnt <= '0;
      r_os_cnt <= '0;
    end else begin
      if (!tx_run || w_tx_wrap) r_tx_cnt <= '0;
      else                      r_tx_cnt <= r_tx_cnt + 1'b1;
      if (!rx_run || w_os_wrap) r_os_cnt <= '0;
      else                      r_os_cnt <= r_os_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_trx_param.sv
// ----------------------------------------------------------------------------
// Module   : uart_trx_param
// Brief    : Parameterised UART transmitter/receiver with internal loopback
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_trx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_W     = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  input  logic              rxd,
  input  logic              lb_en,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_frame_err,
  output logic              rx_parity_err,
  output logic              rx_overrun
);

  localparam int   c_bit_w   = $clog2(DATA_W + 1);
  localparam int   c_os_cw   = $clog2(OVERSAMPLE + 1);
  localparam logic c_par_odd = (PARITY == c_parity_odd);

  generate
    if (DATA_W < 5 || DATA_W > 9) begin : g_err_data_w
      $error("uart_trx_param: DATA_W must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_err_parity
      $error("uart_trx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_err_stop
      $error("uart_trx_param: STOP_BITS must be 1 or 2");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_err_os
      $error("uart_trx_param: OVERSAMPLE must be even and at least 8");
    end
    if (uart_div(CLK_FREQ, BAUD_RATE * OVERSAMPLE) < 1) begin : g_err_div
      $error("uart_trx_param: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
    end
  endgenerate

  tx_state_t         r_tx_state;
  logic [DATA_W-1:0] r_tx_shift;
  logic              r_tx_par;
  logic [c_bit_w-1:0] r_tx_bit;
  logic              r_tx_stop2;
  logic              r_txd;
  logic              r_tx_ready;

  rx_state_t         r_rx_state;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_rx_armed;
  logic [c_os_cw-1:0] r_rx_os;
  logic [c_bit_w-1:0] r_rx_bit;
  logic [DATA_W-1:0] r_rx_shift;
  logic              r_rx_par_bit;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_rx_ferr;
  logic              r_rx_perr;
  logic              r_rx_ovr;

  logic w_tx_tick;
  logic w_os_tick;
  logic w_rx_src;
  logic w_rx_accept;
  logic w_rx_par_calc;

  assign txd           = r_txd;
  assign tx_ready      = r_tx_ready;
  assign rx_data       = r_rx_data;
  assign rx_valid      = r_rx_valid;
  assign rx_frame_err  = r_rx_ferr;
  assign rx_parity_err = r_rx_perr;
  assign rx_overrun    = r_rx_ovr;

  uart_baud_gen #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud_gen (
    .clk     (clk),
    .rst     (rst),
    .tx_run  (r_tx_state != TX_IDLE),
    .rx_run  (r_rx_state != RX_IDLE),
    .tx_tick (w_tx_tick),
    .os_tick (w_os_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx_bit   <= '0;
      r_tx_stop2 <= 1'b0;
      r_txd      <= 1'b1;
      r_tx_ready <= 1'b0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          r_txd      <= 1'b1;
          r_tx_ready <= 1'b1;
          if (tx_valid && r_tx_ready) begin
            r_tx_shift <= tx_data;
            r_tx_par   <= (^tx_data) ^ c_par_odd;
            r_tx_ready <= 1'b0;
            r_txd      <= 1'b0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: if (w_tx_tick) begin
          r_txd      <= r_tx_shift[0];
          r_tx_shift <= r_tx_shift >> 1;
          r_tx_bit   <= '0;
          r_tx_state <= TX_DATA;
        end
        TX_DATA: if (w_tx_tick) begin
          if (r_tx_bit == c_bit_w'(DATA_W - 1)) begin
            r_tx_stop2 <= 1'b0;
            if (PARITY != c_parity_none) begin
              r_txd      <= r_tx_par;
              r_tx_state <= TX_PARITY;
            end else begin
              r_txd      <= 1'b1;
              r_tx_state <= TX_STOP;
            end
          end else begin
            r_txd      <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_bit   <= r_tx_bit + 1'b1;
          end
        end
        TX_PARITY: if (w_tx_tick) begin
          r_txd      <= 1'b1;
          r_tx_stop2 <= 1'b0;
          r_tx_state <= TX_STOP;
        end
        TX_STOP: if (w_tx_tick) begin
          if (r_tx_stop2 || STOP_BITS == 1) begin
            r_tx_ready <= 1'b1;
            r_tx_state <= TX_IDLE;
          end else begin
            r_tx_stop2 <= 1'b1;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // Loopback is muxed ahead of the synchronizer so both sources share it.
  assign w_rx_src = lb_en ? r_txd : rxd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= w_rx_src;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_accept   = r_rx_valid & rx_ready;
  assign w_rx_par_calc = (^r_rx_shift) ^ c_par_odd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state   <= RX_IDLE;
      r_rx_armed   <= 1'b0;
      r_rx_os      <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_rx_par_bit <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_ferr    <= 1'b0;
      r_rx_perr    <= 1'b0;
      r_rx_ovr     <= 1'b0;
    end else begin
      if (w_rx_accept) begin
        r_rx_valid <= 1'b0;
        r_rx_ovr   <= 1'b0;
      end
      case (r_rx_state)
        RX_IDLE: begin
          // armed only after a high sample, so a stuck-low line never restarts
          r_rx_armed <= r_sync2;
          r_rx_os    <= '0;
          if (r_rx_armed && !r_sync2) r_rx_state <= RX_START;
        end
        RX_START: if (w_os_tick) begin
          if (r_rx_os == c_os_cw'(OVERSAMPLE / 2 - 1)) begin
            r_rx_os  <= '0;
            r_rx_bit <= '0;
            r_rx_state <= r_sync2 ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_os <= r_rx_os + 1'b1;
          end
        end
        RX_DATA: if (w_os_tick) begin
          if (r_rx_os == c_os_cw'(OVERSAMPLE - 1)) begin
            r_rx_os    <= '0;
            r_rx_shift <= {r_sync2, r_rx_shift[DATA_W-1:1]};
            if (r_rx_bit == c_bit_w'(DATA_W - 1))
              r_rx_state <= (PARITY != c_parity_none) ? RX_PARITY : RX_STOP;
            else
              r_rx_bit <= r_rx_bit + 1'b1;
          end else begin
            r_rx_os <= r_rx_os + 1'b1;
          end
        end
        RX_PARITY: if (w_os_tick) begin
          if (r_rx_os == c_os_cw'(OVERSAMPLE - 1)) begin
            r_rx_os      <= '0;
            r_rx_par_bit <= r_sync2;
            r_rx_state   <= RX_STOP;
          end else begin
            r_rx_os <= r_rx_os + 1'b1;
          end
        end
        RX_STOP: if (w_os_tick) begin
          if (r_rx_os == c_os_cw'(OVERSAMPLE - 1)) begin
            r_rx_os    <= '0;
            r_rx_data  <= r_rx_shift;
            r_rx_ferr  <= ~r_sync2;
            r_rx_perr  <= (PARITY != c_parity_none) && (w_rx_par_calc != r_rx_par_bit);
            r_rx_valid <= 1'b1;
            r_rx_ovr   <= r_rx_valid & ~rx_ready;
            r_rx_armed <= 1'b0;
            r_rx_state <= RX_IDLE;
          end else begin
            r_rx_os <= r_rx_os + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
